// File: rtl/gpio_input_irq_if.sv
// Register-side bundle of the GPIO input/interrupt stage: configuration
// driven by the register slave, conditioned status returned to it.
interface gpio_input_irq_if #(
  parameter int WIDTH      = 8,
  parameter int DEBOUNCE_W = 16
);
  logic [WIDTH-1:0]      input_en;
  logic [DEBOUNCE_W-1:0] debounce_limit;
  logic [WIDTH-1:0]      rise_en;
  logic [WIDTH-1:0]      fall_en;
  logic [WIDTH-1:0]      irq_mask;
  logic [WIDTH-1:0]      pend_clr;
  logic [WIDTH-1:0]      pin_val;
  logic [WIDTH-1:0]      pending;
  logic                  irq;

  modport master (
    output input_en, debounce_limit, rise_en, fall_en, irq_mask, pend_clr,
    input  pin_val, pending, irq
  );

  modport slave (
    input  input_en, debounce_limit, rise_en, fall_en, irq_mask, pend_clr,
    output pin_val, pending, irq
  );
endinterface

// File: rtl/gpio_input_irq.sv
// GPIO input conditioning: per-bit synchroniser, programmable debounce,
// edge detection into a write-1-to-clear pending register, and a single
// level interrupt built only from flops and the mask.
module gpio_input_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_raw,
  gpio_input_irq_if.slave  bus
);

  logic [WIDTH-1:0]      sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]      s;
  logic [DEBOUNCE_W-1:0] cnt_q [WIDTH];
  logic [WIDTH-1:0]      pin_val_q;
  logic [WIDTH-1:0]      pending_q;
  logic [WIDTH-1:0]      update;
  logic [WIDTH-1:0]      edge_set;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; runs independently of input_en so a re-enabled bit
  // immediately sees the current pad level.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pin_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Update event: bit enabled, differs from the stable value, and has been
  // different long enough. >= also covers a limit lowered mid-count.
  always_comb begin
    update   = '0;
    edge_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      update[i] = bus.input_en[i] && (s[i] != pin_val_q[i]) &&
                  (cnt_q[i] >= bus.debounce_limit);
      edge_set[i] = update[i] &&
                    ((s[i] && bus.rise_en[i]) || (!s[i] && bus.fall_en[i]));
    end
  end

  // Per-bit debounce counters and stable value; counters saturate at the
  // limit by construction because reaching it always resets them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      pin_val_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!bus.input_en[i] || (s[i] == pin_val_q[i])) begin
          cnt_q[i] <= '0;
        end else if (update[i]) begin
          cnt_q[i]     <= '0;
          pin_val_q[i] <= s[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + DEBOUNCE_W'(1);
        end
      end
    end
  end

  // Pending register: a new edge in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= (pending_q & ~bus.pend_clr) | edge_set;
  end

  assign bus.pin_val = pin_val_q;
  assign bus.pending = pending_q;
  assign bus.irq     = |(pending_q & bus.irq_mask);

endmodule
